// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the instruction-fetch
// port and the data-memory port.
//   clk, rst (async, active-low)
//   if_req/if_addr  -> if_ready pulse, if_rdata (held)
//   dm_rd/dm_wr/dm_addr/dm_wdata -> dm_ready pulse, dm_rdata (held)
//   mem_req/mem_we/mem_addr/mem_wdata -> memory, mem_ack/mem_rdata <- memory
//   busy: FSM is not idle
// Data wins arbitration unless it has already overtaken a waiting fetch
// STREAK_MAX times in a row. Every output is registered.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ready,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned SW = (STREAK_MAX < 1) ? 1 : $clog2(STREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_LIM = SW'(STREAK_MAX);

  typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D, DONE} state_e;

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ready_q, if_ready_d;
  logic              dm_ready_q, dm_ready_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic              busy_q, busy_d;
  logic              dm_pend;

  assign dm_pend = dm_rd | dm_wr;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    streak_d    = streak_q;

    case (state_q)
      IDLE: begin
        if (dm_pend && (!if_req || streak_q < STREAK_LIM)) begin
          state_d     = WAIT_D;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_wr;  // rd+wr together behaves as a write
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          // A data grant with fetch waiting only happens below the limit,
          // so the increment cannot pass STREAK_LIM.
          streak_d    = if_req ? streak_q + SW'(1) : '0;
        end else if (if_req) begin
          state_d    = WAIT_I;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
          streak_d   = '0;
        end
      end
      WAIT_I: begin
        if (mem_ack) begin
          state_d    = DONE;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          if_rdata_d = mem_rdata;
          if_ready_d = 1'b1;
        end
      end
      WAIT_D: begin
        if (mem_ack) begin
          state_d    = DONE;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          if (!mem_we_q) begin
            dm_rdata_d = mem_rdata;
          end
          dm_ready_d = 1'b1;
        end
      end
      // One idle-ish cycle so requesters can drop or change their request
      // after seeing ready, before arbitration samples again.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      streak_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      streak_q    <= streak_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic from
// two requester agents and a memory responder with random ack delay.
module tb_mem_port_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned SMAX = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_ready;
  logic [DW-1:0] if_rdata;
  logic          dm_rd = 1'b0;
  logic          dm_wr = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic          dm_ready;
  logic [DW-1:0] dm_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STREAK_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] exp_if[$];
  logic [31:0] exp_dm[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] mem_model[logic [31:0]];
  logic [31:0] last_load = '0;
  int          ref_streak = 0;   // data grants that overtook the waiting fetch
  string       grant_log = "";
  bit          log_en = 1'b0;

  // Responder controls
  int ack_delay  = 0;
  bit rand_delay = 1'b0;
  bit stray_ack  = 1'b0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h40) return 32'h8C010004;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : init_word(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic issue_if(input logic [31:0] a);
    if_addr = a;
    if_req  = 1'b1;
    exp_if.push_back(ref_rd(a));
  endtask

  task automatic issue_dm(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    dm_rd    = rd;
    dm_wr    = wr;
    dm_addr  = a;
    dm_wdata = d;
    if (wr) ref_mem[a] = d;
    else    last_load = ref_rd(a);
    exp_dm.push_back(last_load);
  endtask

  // Returns the cycle index (first negedge after issue = 1) of the ready pulse.
  task automatic wait_if(output int c);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if_ready && n < 200);
    if (!if_ready) chkb("if_ready_timeout", if_ready, 1'b1);
    if_req = 1'b0;
    c = n;
  endtask

  task automatic wait_dm(output int c);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dm_ready && n < 200);
    if (!dm_ready) chkb("dm_ready_timeout", dm_ready, 1'b1);
    dm_rd = 1'b0;
    dm_wr = 1'b0;
    c = n;
  endtask

  // Memory responder: acks after ack_delay (or random 0..3) waiting cycles.
  initial begin
    int cnt = 0;
    bit active = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst || !mem_req) begin
        active    = 1'b0;
        mem_ack   = stray_ack;
        mem_rdata = stray_ack ? 32'hBAD0BAD0 : $urandom;
      end else begin
        if (!active) begin
          active = 1'b1;
          cnt = rand_delay ? int'($urandom_range(0, 3)) : ack_delay;
        end
        if (cnt == 0) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            mem_model[mem_addr] = mem_wdata;
            mem_rdata = $urandom;
          end else begin
            mem_rdata = model_rd(mem_addr);
          end
        end else begin
          cnt--;
          mem_ack   = 1'b0;
          mem_rdata = $urandom;
        end
      end
    end
  end

  // Monitor / scoreboard: samples just after each rising edge.
  initial begin
    logic          p_req = 1'b0;
    logic          p_we = 1'b0;
    logic          p_rdy = 1'b0;
    logic [31:0]   p_addr = '0;
    logic [31:0]   p_wdata = '0;
    logic          acked;
    bit            pend_d, take_d;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        p_req = 1'b0;
        p_rdy = 1'b0;
        ref_streak = 0;
        continue;
      end
      acked = p_req && mem_ack;
      if (if_ready || dm_ready || acked) begin
        chkb("ready_after_ack", if_ready | dm_ready, acked);
        chkb("ready_exclusive", if_ready & dm_ready, 1'b0);
        if (acked) chkb("req_drop_on_ack", mem_req, 1'b0);
      end
      chkb("busy", busy, mem_req | if_ready | dm_ready);
      if (if_ready) begin
        if (exp_if.size() == 0) chkb("if_unexpected", if_ready, 1'b0);
        else chk("if_rdata", if_rdata, exp_if.pop_front());
      end
      if (dm_ready) begin
        if (exp_dm.size() == 0) chkb("dm_unexpected", dm_ready, 1'b0);
        else chk("dm_rdata", dm_rdata, exp_dm.pop_front());
      end
      if (p_req && mem_req) begin
        chk("mem_addr_stable", mem_addr, p_addr);
        chk("mem_wdata_stable", mem_wdata, p_wdata);
        chkb("mem_we_stable", mem_we, p_we);
      end
      if (mem_req && !p_req) begin
        chkb("no_grant_from_done", p_rdy, 1'b0);
        pend_d = dm_rd | dm_wr;
        take_d = pend_d && (!if_req || ref_streak < int'(SMAX));
        if (!pend_d && !if_req) begin
          chkb("spurious_grant", mem_req, 1'b0);
        end else if (take_d) begin
          chk("grant_d_addr", mem_addr, dm_addr);
          chkb("grant_d_we", mem_we, dm_wr);
          if (dm_wr) chk("grant_d_wdata", mem_wdata, dm_wdata);
          ref_streak = if_req ? ref_streak + 1 : 0;
          if (log_en) grant_log = {grant_log, "D"};
        end else begin
          chk("grant_i_addr", mem_addr, if_addr);
          chkb("grant_i_we", mem_we, 1'b0);
          ref_streak = 0;
          if (log_en) grant_log = {grant_log, "I"};
        end
      end
      p_req   = mem_req;
      p_we    = mem_we;
      p_addr  = mem_addr;
      p_wdata = mem_wdata;
      p_rdy   = if_ready | dm_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    int c1, c2, c;
    repeat (3) @(negedge clk);
    chkb("rst_mem_req", mem_req, 1'b0);
    chkb("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chkb("rst_if_ready", if_ready, 1'b0);
    chkb("rst_dm_ready", dm_ready, 1'b0);
    chk("rst_if_rdata", if_rdata, '0);
    chk("rst_dm_rdata", dm_rdata, '0);
    chkb("rst_busy", busy, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    // Fetch with immediate ack
    ack_delay = 0;
    issue_if(32'h40);
    @(negedge clk);
    chkb("t1_mem_req", mem_req, 1'b1);
    chk("t1_mem_addr", mem_addr, 32'h40);
    chkb("t1_mem_we", mem_we, 1'b0);
    chkb("t1_busy_c1", busy, 1'b1);
    @(negedge clk);
    chkb("t1_if_ready", if_ready, 1'b1);
    chk("t1_if_rdata", if_rdata, 32'h8C010004);
    chkb("t1_busy_c2", busy, 1'b1);
    if_req = 1'b0;
    @(negedge clk);
    chkb("t1_ready_pulse", if_ready, 1'b0);
    chkb("t1_busy_c3", busy, 1'b0);

    // Write with ack delayed 3 cycles
    ack_delay = 3;
    issue_dm(1'b0, 1'b1, 32'h100, 32'hDEADBEEF);
    for (int unsigned i = 1; i <= 4; i++) begin
      @(negedge clk);
      chkb("t2_mem_req", mem_req, 1'b1);
      chkb("t2_mem_we", mem_we, 1'b1);
      chk("t2_mem_addr", mem_addr, 32'h100);
      chk("t2_mem_wdata", mem_wdata, 32'hDEADBEEF);
      chkb("t2_no_early_ready", dm_ready, 1'b0);
    end
    @(negedge clk);
    chkb("t2_dm_ready_c5", dm_ready, 1'b1);
    chk("t2_dm_rdata_kept", dm_rdata, 32'h0);
    dm_wr = 1'b0;
    @(negedge clk);
    ack_delay = 0;

    // Simultaneous fetch and load: data first
    issue_if(32'h80);
    issue_dm(1'b1, 1'b0, 32'h100, 32'h0);
    fork
      wait_if(c1);
      wait_dm(c2);
    join
    chk("t3_dm_cycle", c2, 2);
    chk("t3_if_cycle", c1, 5);
    @(negedge clk);

    // Streak limit with fetch held pending
    grant_log = "";
    log_en = 1'b1;
    issue_if(32'h84);
    fork
      begin
        wait_if(c1);
        issue_if(32'h88);
        wait_if(c2);
      end
      begin
        for (int unsigned i = 0; i < 8; i++) begin
          issue_dm(1'b1, 1'b0, 32'h1000 + 32'(i * 4), 32'h0);
          wait_dm(c);
        end
      end
    join
    log_en = 1'b0;
    total++;
    if (grant_log != "DDDDIDDDDI") begin
      bad++;
      $display("FAIL t4_grant_order: got %s expected DDDDIDDDDI", grant_log);
    end
    chk("t4_if1_cycle", c1, 14);
    chk("t4_if2_cycle", c2, 15);
    @(negedge clk);

    // Reset in the middle of a data wait
    ack_delay = 20;
    issue_dm(1'b1, 1'b0, 32'h1004, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chkb("t5_in_wait", mem_req, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chkb("t5_async_req", mem_req, 1'b0);
    chkb("t5_async_busy", busy, 1'b0);
    dm_rd = 1'b0;
    exp_dm.delete();
    last_load = '0;
    @(negedge clk);
    rst = 1'b1;
    ack_delay = 0;
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      chkb("t5_idle_busy", busy, 1'b0);
      chkb("t5_idle_req", mem_req, 1'b0);
      chkb("t5_no_dm_ready", dm_ready, 1'b0);
    end

    // rd+wr together is a write; then a stray ack while idle
    issue_dm(1'b1, 1'b0, 32'h100, 32'h0);
    wait_dm(c);
    @(negedge clk);
    issue_dm(1'b1, 1'b1, 32'h200, 32'h12345678);
    @(negedge clk);
    chkb("t6_mem_we", mem_we, 1'b1);
    chk("t6_mem_wdata", mem_wdata, 32'h12345678);
    chk("t6_mem_addr", mem_addr, 32'h200);
    wait_dm(c);
    chk("t6_dm_cycle", c, 1);
    chk("t6_dm_rdata_kept", dm_rdata, 32'hDEADBEEF);
    @(negedge clk);
    @(posedge clk);
    #2 stray_ack = 1'b1;
    @(posedge clk);
    #2 stray_ack = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      chkb("t6_stray_busy", busy, 1'b0);
      chkb("t6_stray_req", mem_req, 1'b0);
    end

    // Randomized traffic
    rand_delay = 1'b1;
    fork
      begin
        for (int unsigned i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          issue_if(32'($urandom_range(0, 1023)) * 32'd4);
          wait_if(c1);
        end
      end
      begin
        for (int unsigned i = 0; i < 40; i++) begin
          int unsigned op;
          repeat ($urandom_range(0, 3)) @(negedge clk);
          op = $urandom_range(0, 2);
          issue_dm(op != 1, op != 0, 32'h1000 + 32'($urandom_range(0, 15)) * 32'd4, $urandom);
          wait_dm(c2);
        end
      end
    join
    repeat (3) @(negedge clk);
    chk("drain_if", exp_if.size(), 0);
    chk("drain_dm", exp_dm.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
